// File: rtl/cpu_commit_pkg.sv
// Shared types and width helpers for the commit/memory stage.
package cpu_commit_pkg;

    localparam int unsigned CommitXlen = 32;
    localparam int unsigned CommitRegW = 5;
    localparam int unsigned CommitBeW  = CommitXlen / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } commit_state_t;

    // Hold-register widths follow CommitXlen/CommitRegW; the stage parameters default to them.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  byte_acc;
        logic [CommitRegW-1:0] reg_dest;
        logic [CommitXlen-1:0] addr;
        logic [CommitXlen-1:0] wdata;
    } commit_hold_t;

    // Width of the byte-lane index inside a word.
    function automatic int unsigned lane_idx_w(int unsigned be_w);
        return (be_w > 1) ? $clog2(be_w) : 1;
    endfunction

endpackage

// File: rtl/cpu_commit_lane.sv
// Combinational byte-lane steering: byte enables, store replication and load-byte extraction.
module cpu_commit_lane
    import cpu_commit_pkg::*;
#(
    parameter int unsigned XLEN = CommitXlen,
    parameter int unsigned BE_W = XLEN / 8
) (
    input  logic            byte_acc_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] req_addr_o,
    output logic [BE_W-1:0] be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] load_value_o
);

    localparam int unsigned LaneW = lane_idx_w(BE_W);

    logic [LaneW-1:0] lane;

    assign lane = addr_i[LaneW-1:0];

    always_comb begin
        req_addr_o   = addr_i;
        be_o         = '1;
        wdata_o      = store_data_i;
        load_value_o = rdata_i;
        if (byte_acc_i) begin
            be_o         = BE_W'(1) << lane;
            wdata_o      = {BE_W{store_data_i[7:0]}};
            load_value_o = {{(XLEN-8){1'b0}}, rdata_i[{lane, 3'b000} +: 8]};
        end else begin
            req_addr_o = {addr_i[XLEN-1:LaneW], {LaneW{1'b0}}};
        end
    end

endmodule

// File: rtl/cpu_commit_mem.sv
// Commit stage with a data-memory path and forwarding outputs.
// Optional performance counters are enabled with the CPU_COMMIT_PERF_EN macro.
module cpu_commit_mem
    import cpu_commit_pkg::*;
#(
    parameter int unsigned XLEN  = CommitXlen,
    parameter int unsigned REG_W = CommitRegW,
    parameter int unsigned BE_W  = XLEN / 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic             in_byte,
    input  logic [REG_W-1:0] in_reg_dest,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_store_data,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_write,
    output logic [XLEN-1:0]  mem_req_addr,
    output logic [XLEN-1:0]  mem_req_wdata,
    output logic [BE_W-1:0]  mem_req_be,
    input  logic             mem_rsp_valid,
    input  logic [XLEN-1:0]  mem_rsp_rdata,
    output logic [REG_W-1:0] fw_reg_dest,
    output logic             fw_reg_write,
    output logic [XLEN-1:0]  fw_value,
    output logic             fw_load_pending,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic [REG_W-1:0] wb_reg_dest,
    output logic [XLEN-1:0]  wb_data
`ifdef CPU_COMMIT_PERF_EN
    ,
    output logic [31:0]      perf_retired,
    output logic [31:0]      perf_mem_stall,
    output logic [31:0]      perf_loads
`endif
);

    commit_state_t    state_q, state_d;
    commit_hold_t     hold_q, hold_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic [REG_W-1:0] wb_reg_dest_q, wb_reg_dest_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [XLEN-1:0]  load_value;

    cpu_commit_lane #(
        .XLEN (XLEN),
        .BE_W (BE_W)
    ) u_lane (
        .byte_acc_i   (hold_q.byte_acc),
        .addr_i       (hold_q.addr),
        .store_data_i (hold_q.wdata),
        .rdata_i      (mem_rsp_rdata),
        .req_addr_o   (mem_req_addr),
        .be_o         (mem_req_be),
        .wdata_o      (mem_req_wdata),
        .load_value_o (load_value)
    );

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_reg_dest_d  = wb_reg_dest_q;
        wb_data_d      = wb_data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_mem_read || in_mem_write) begin
                        hold_d.reg_write = in_reg_write;
                        hold_d.mem_read  = in_mem_read;
                        hold_d.mem_write = in_mem_write;
                        hold_d.byte_acc  = in_byte;
                        hold_d.reg_dest  = in_reg_dest;
                        hold_d.addr      = in_alu_result;
                        hold_d.wdata     = in_store_data;
                        state_d          = REQ;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = in_reg_write;
                        wb_reg_dest_d  = in_reg_dest;
                        wb_data_d      = in_alu_result;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (hold_q.mem_write) begin
                        // Stores are posted: retire as soon as the request is taken.
                        state_d        = IDLE;
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d        = IDLE;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = hold_q.reg_write;
                    wb_reg_dest_d  = hold_q.reg_dest;
                    wb_data_d      = load_value;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_reg_dest_q  <= '0;
            wb_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_reg_dest_q  <= wb_reg_dest_d;
            wb_data_q      <= wb_data_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_write = hold_q.mem_write;

    always_comb begin
        fw_reg_dest     = in_reg_dest;
        fw_value        = in_alu_result;
        fw_reg_write    = in_valid && in_reg_write && !in_mem_read;
        fw_load_pending = 1'b0;
        if (state_q != IDLE) begin
            fw_reg_dest     = hold_q.reg_dest;
            fw_value        = hold_q.addr;
            fw_reg_write    = 1'b0;
            fw_load_pending = hold_q.mem_read;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_reg_dest  = wb_reg_dest_q;
    assign wb_data      = wb_data_q;

`ifdef CPU_COMMIT_PERF_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_mem_stall_q, perf_mem_stall_d;
    logic [31:0] perf_loads_q, perf_loads_d;

    always_comb begin
        perf_retired_d   = perf_retired_q;
        perf_mem_stall_d = perf_mem_stall_q;
        perf_loads_d     = perf_loads_q;
        if (wb_valid_d) begin
            perf_retired_d = perf_retired_q + 32'd1;
        end
        if (state_q != IDLE) begin
            perf_mem_stall_d = perf_mem_stall_q + 32'd1;
        end
        if ((state_q == WAIT) && mem_rsp_valid) begin
            perf_loads_d = perf_loads_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_retired_q   <= '0;
            perf_mem_stall_q <= '0;
            perf_loads_q     <= '0;
        end else begin
            perf_retired_q   <= perf_retired_d;
            perf_mem_stall_q <= perf_mem_stall_d;
            perf_loads_q     <= perf_loads_d;
        end
    end

    assign perf_retired   = perf_retired_q;
    assign perf_mem_stall = perf_mem_stall_q;
    assign perf_loads     = perf_loads_q;
`endif

endmodule

// File: tb/tb_cpu_commit_mem.sv
// Directed bench for cpu_commit_mem with a writeback scoreboard.
module tb_cpu_commit_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_reg_write, in_mem_read, in_mem_write, in_byte;
    logic [4:0]  in_reg_dest;
    logic [31:0] in_alu_result, in_store_data;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic [4:0]  fw_reg_dest;
    logic        fw_reg_write;
    logic [31:0] fw_value;
    logic        fw_load_pending;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_reg_dest;
    logic [31:0] wb_data;
`ifdef CPU_COMMIT_PERF_EN
    logic [31:0] perf_retired, perf_mem_stall, perf_loads;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        reg_write;
        logic        full;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    cpu_commit_mem dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_reg_write    (in_reg_write),
        .in_mem_read     (in_mem_read),
        .in_mem_write    (in_mem_write),
        .in_byte         (in_byte),
        .in_reg_dest     (in_reg_dest),
        .in_alu_result   (in_alu_result),
        .in_store_data   (in_store_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_be      (mem_req_be),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_rdata   (mem_rsp_rdata),
        .fw_reg_dest     (fw_reg_dest),
        .fw_reg_write    (fw_reg_write),
        .fw_value        (fw_value),
        .fw_load_pending (fw_load_pending),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_reg_dest     (wb_reg_dest),
        .wb_data         (wb_data)
`ifdef CPU_COMMIT_PERF_EN
        ,
        .perf_retired    (perf_retired),
        .perf_mem_stall  (perf_mem_stall),
        .perf_loads      (perf_loads)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic rw, input logic full, input logic [4:0] d,
                        input logic [31:0] v);
        exp_t e;
        e.reg_write = rw;
        e.full      = full;
        e.dest      = d;
        e.data      = v;
        sb.push_back(e);
    endtask

    task automatic drive_entry(input logic rw, input logic rd, input logic wr, input logic by,
                               input logic [4:0] d, input logic [31:0] a, input logic [31:0] s);
        in_valid      = 1'b1;
        in_reg_write  = rw;
        in_mem_read   = rd;
        in_mem_write  = wr;
        in_byte       = by;
        in_reg_dest   = d;
        in_alu_result = a;
        in_store_data = s;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_reg_write  = 1'b0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_byte       = 1'b0;
        in_reg_dest   = '0;
        in_alu_result = '0;
        in_store_data = '0;
    endtask

    // Every writeback pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset && wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", wb_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_reg_write", wb_reg_write, e.reg_write);
                if (e.full) begin
                    check("wb_reg_dest", wb_reg_dest, e.dest);
                    check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin
        reset         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        idle_inputs();
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_req_valid", mem_req_valid, 1'b0);
        reset = 1'b1;
        tick();

        // ALU op, then two back-to-back ALU ops
        drive_entry(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h1234, 32'h0);
        #1;
        check("alu_fw_value", fw_value, 32'h1234);
        check("alu_fw_reg_write", fw_reg_write, 1'b1);
        check("alu_fw_dest", fw_reg_dest, 5'd3);
        push(1'b1, 1'b1, 5'd3, 32'h1234);
        tick();
        check("alu_wb_valid", wb_valid, 1'b1);
        drive_entry(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h55, 32'h0);
        push(1'b1, 1'b1, 5'd4, 32'h55);
        tick();
        drive_entry(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h66, 32'h0);
        push(1'b0, 1'b1, 5'd5, 32'h66);
        tick();
        check("b2b_wb_valid", wb_valid, 1'b1);
        idle_inputs();
        tick();
        check("idle_wb_valid", wb_valid, 1'b0);

        // Word load at 0x104, request accepted after 2 cycles, response 3 cycles later
        drive_entry(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h104, 32'h0);
        #1;
        check("ld_fw_reg_write", fw_reg_write, 1'b0);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_req_ready = 1'b1;
            #1;
            check("ld_req_valid", mem_req_valid, 1'b1);
            check("ld_req_addr", mem_req_addr, 32'h104);
            check("ld_req_be", mem_req_be, 4'hF);
            check("ld_req_write", mem_req_write, 1'b0);
            check("ld_in_ready", in_ready, 1'b0);
            check("ld_pending", fw_load_pending, 1'b1);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_req_valid", mem_req_valid, 1'b0);
            check("ld_wait_in_ready", in_ready, 1'b0);
            check("ld_wait_pending", fw_load_pending, 1'b1);
            if (i == 2) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = 32'hDEADBEEF;
                push(1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
            end
            tick();
        end
        mem_rsp_valid = 1'b0;
        check("ld_wb_valid", wb_valid, 1'b1);
        check("ld_wb_data", wb_data, 32'hDEADBEEF);
        check("ld_in_ready_after", in_ready, 1'b1);

        // Byte store at 0x203 with data low byte 0xA5
        drive_entry(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h203, 32'h123456A5);
        tick();
        idle_inputs();
        mem_req_ready = 1'b1;
        #1;
        check("bst_be", mem_req_be, 4'h8);
        check("bst_wdata", mem_req_wdata, 32'hA5A5A5A5);
        check("bst_addr", mem_req_addr, 32'h203);
        check("bst_write", mem_req_write, 1'b1);
        check("bst_pending", fw_load_pending, 1'b0);
        push(1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        mem_req_ready = 1'b0;
        check("bst_wb_valid", wb_valid, 1'b1);
        check("bst_wb_reg_write", wb_reg_write, 1'b0);
        check("bst_in_ready", in_ready, 1'b1);

        // Word store at unaligned 0x107: address aligned, full enables
        drive_entry(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h107, 32'hCAFEF00D);
        tick();
        idle_inputs();
        mem_req_ready = 1'b1;
        #1;
        check("wst_addr", mem_req_addr, 32'h104);
        check("wst_be", mem_req_be, 4'hF);
        check("wst_wdata", mem_req_wdata, 32'hCAFEF00D);
        push(1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        mem_req_ready = 1'b0;

        // Byte loads: lane 1 and lane 3
        drive_entry(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h201, 32'h0);
        tick();
        idle_inputs();
        mem_req_ready = 1'b1;
        #1;
        check("bld_be", mem_req_be, 4'h2);
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h11223344;
        push(1'b1, 1'b1, 5'd9, 32'h00000033);
        tick();
        mem_rsp_valid = 1'b0;
        drive_entry(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h3, 32'h0);
        tick();
        idle_inputs();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hAABBCCDD;
        push(1'b1, 1'b1, 5'd10, 32'h000000AA);
        tick();
        mem_rsp_valid = 1'b0;
        tick();

        // Reset while a load waits; the late response must be ignored
        drive_entry(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h40, 32'h0);
        tick();
        idle_inputs();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("rw_pending", fw_load_pending, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h99999999;
        tick();
        mem_rsp_valid = 1'b0;
        check("rw_in_ready", in_ready, 1'b1);
        check("rw_wb_valid", wb_valid, 1'b0);
        check("rw_wb_reg_write", wb_reg_write, 1'b0);
        check("rw_wb_dest", wb_reg_dest, 5'd0);
        check("rw_wb_data", wb_data, 32'h0);
        check("rw_req_valid", mem_req_valid, 1'b0);
        check("rw_pending_clr", fw_load_pending, 1'b0);
        check("rw_fw_reg_write", fw_reg_write, 1'b0);
        tick();
        check("rw_wb_valid_late", wb_valid, 1'b0);

`ifdef CPU_COMMIT_PERF_EN
        check("perf_rst_retired", perf_retired, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_entry(1'b1, 1'b0, 1'b0, 1'b0, 5'(i + 1), 32'(i), 32'h0);
            push(1'b1, 1'b1, 5'(i + 1), 32'(i));
            tick();
        end
        drive_entry(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h80, 32'h0);
        tick();
        idle_inputs();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0BADF00D;
        push(1'b1, 1'b1, 5'd8, 32'h0BADF00D);
        tick();
        mem_rsp_valid = 1'b0;
        check("perf_retired", perf_retired, 32'd4);
        check("perf_loads", perf_loads, 32'd1);
        check("perf_mem_stall", perf_mem_stall, 32'd4);
`endif

        tick();
        tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
